// File: rtl/wb_writeback_unit.sv
// Writeback stage: commits scalar results to the RF and drains 8-lane vector results to a narrow VRF port.
// Optional macro WB_FWD_EN adds combinational fwd_* outputs mirroring the next-cycle scalar write.
module wb_writeback_unit #(
   parameter  int DATA_W         = 32,
   parameter  int LANES          = 8,
   parameter  int LANES_PER_BEAT = 2,
   parameter  int REG_AW         = 5,
   localparam int NBEATS         = LANES / LANES_PER_BEAT,
   localparam int BW             = (NBEATS > 1) ? $clog2(NBEATS) : 1,
   localparam int BEAT_W         = LANES_PER_BEAT * DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      RegWrite_i,
   input  logic                      MemtoReg_i,
   input  logic [DATA_W-1:0]         alu_result_i,
   input  logic [DATA_W-1:0]         read_data_i,
   input  logic [REG_AW-1:0]         write_addr_i,
   input  logic                      VRegWrite_i,
   input  logic [LANES*DATA_W-1:0]   vec_data_i,
   output logic                      rf_we,
   output logic [REG_AW-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic                      vrf_we,
   output logic [REG_AW-1:0]         vrf_waddr,
   output logic [BW-1:0]             vrf_beat,
   output logic [BEAT_W-1:0]         vrf_wdata,
   output logic                      busy
`ifdef WB_FWD_EN
   ,
   output logic                      fwd_valid,
   output logic [REG_AW-1:0]         fwd_addr,
   output logic [DATA_W-1:0]         fwd_data
`endif
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [LANES*DATA_W-1:0]   buf_q, buf_d;
   logic [REG_AW-1:0]         vaddr_q, vaddr_d;
   logic                      vrf_we_q, vrf_we_d;
   logic                      rf_we_q, rf_we_d;
   logic [REG_AW-1:0]         rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]         rf_wdata_q, rf_wdata_d;

   logic                      last_beat;
   logic                      accept;
   logic                      scalar_wr;
   logic                      vec_acc;
   logic [DATA_W-1:0]         scalar_data;

   // The final beat frees the buffer, so a new op may be taken in that same cycle.
   always_comb begin
      last_beat   = vrf_we_q && (beat_q == BW'(NBEATS - 1));
      in_ready    = (state_q == S_IDLE) || last_beat;
      accept      = in_valid && in_ready;
      scalar_wr   = accept && RegWrite_i && (write_addr_i != '0);
      vec_acc     = accept && VRegWrite_i;
      scalar_data = MemtoReg_i ? read_data_i : alu_result_i;
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      buf_d      = buf_q;
      vaddr_d    = vaddr_q;
      vrf_we_d   = 1'b0;
      rf_we_d    = scalar_wr;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      if (vec_acc) begin
         buf_d    = vec_data_i;
         vaddr_d  = write_addr_i;
         beat_d   = '0;
         vrf_we_d = 1'b1;
         state_d  = (NBEATS > 1) ? S_DRAIN : S_IDLE;
      end else if (state_q == S_DRAIN) begin
         if (last_beat) begin
            state_d = S_IDLE;
         end else begin
            beat_d   = beat_q + BW'(1);
            vrf_we_d = 1'b1;
         end
      end

      if (scalar_wr) begin
         rf_waddr_d = write_addr_i;
         rf_wdata_d = scalar_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         buf_q      <= '0;
         vaddr_q    <= '0;
         vrf_we_q   <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         buf_q      <= buf_d;
         vaddr_q    <= vaddr_d;
         vrf_we_q   <= vrf_we_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Beat select: lowest lane of the beat lands at the LSBs.
   always_comb begin
      vrf_wdata = '0;
      for (int b = 0; b < NBEATS; b++) begin
         if (beat_q == BW'(b)) begin
            vrf_wdata = buf_q[b*BEAT_W +: BEAT_W];
         end
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign vrf_we    = vrf_we_q;
   assign vrf_waddr = vaddr_q;
   assign vrf_beat  = beat_q;
   assign busy      = (state_q == S_DRAIN);

`ifdef WB_FWD_EN
   assign fwd_valid = scalar_wr;
   assign fwd_addr  = write_addr_i;
   assign fwd_data  = scalar_data;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: directed scenarios plus randomized traffic against a beat-queue reference model.
module tb_wb_writeback_unit;

   localparam int DATA_W = 32;
   localparam int LANES  = 8;
   localparam int LPB    = 2;
   localparam int REG_AW = 5;
   localparam int NBEATS = LANES / LPB;
   localparam int BW     = 2;
   localparam int BEAT_W = LPB * DATA_W;
   localparam int VW     = LANES * DATA_W;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                RegWrite_i;
   logic                MemtoReg_i;
   logic [DATA_W-1:0]   alu_result_i;
   logic [DATA_W-1:0]   read_data_i;
   logic [REG_AW-1:0]   write_addr_i;
   logic                VRegWrite_i;
   logic [VW-1:0]       vec_data_i;
   logic                rf_we;
   logic [REG_AW-1:0]   rf_waddr;
   logic [DATA_W-1:0]   rf_wdata;
   logic                vrf_we;
   logic [REG_AW-1:0]   vrf_waddr;
   logic [BW-1:0]       vrf_beat;
   logic [BEAT_W-1:0]   vrf_wdata;
   logic                busy;
`ifdef WB_FWD_EN
   logic                fwd_valid;
   logic [REG_AW-1:0]   fwd_addr;
   logic [DATA_W-1:0]   fwd_data;
`endif

   always #5 clk = ~clk;

   wb_writeback_unit #(
      .DATA_W(DATA_W), .LANES(LANES), .LANES_PER_BEAT(LPB), .REG_AW(REG_AW)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
      .alu_result_i(alu_result_i), .read_data_i(read_data_i),
      .write_addr_i(write_addr_i), .VRegWrite_i(VRegWrite_i), .vec_data_i(vec_data_i),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_beat(vrf_beat), .vrf_wdata(vrf_wdata),
      .busy(busy)
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
   );

   // Reference model: a queue of VRF beats still owed, head = beat on the port now.
   typedef struct {
      logic [REG_AW-1:0] addr;
      int                beat;
      logic [BEAT_W-1:0] data;
   } beat_t;

   beat_t             mq[$];
   logic              m_rf_we;
   logic [REG_AW-1:0] m_rf_waddr;
   logic [DATA_W-1:0] m_rf_wdata;
   bit                m_just_reset;
   int                n_checks;
   int                n_errors;

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input bit rw, input bit m2r, input bit vrw,
                             input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rd,
                             input logic [REG_AW-1:0] a, input logic [VW-1:0] vec);
      bit acc;
      if (r) begin
         mq.delete();
         m_rf_we      = 1'b0;
         m_rf_waddr   = '0;
         m_rf_wdata   = '0;
         m_just_reset = 1'b1;
         return;
      end
      m_just_reset = 1'b0;
      acc = v && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc && vrw) begin
         for (int b = 0; b < NBEATS; b++) begin
            beat_t e;
            e.addr = a;
            e.beat = b;
            e.data = vec[b*BEAT_W +: BEAT_W];
            mq.push_back(e);
         end
      end
      m_rf_we = acc && rw && (a != '0);
      if (m_rf_we) begin
         m_rf_waddr = a;
         m_rf_wdata = m2r ? rd : alu;
      end
   endtask

   task automatic check_all();
      chk("in_ready", VW'(in_ready), VW'(mq.size() <= 1));
      chk("busy", VW'(busy), VW'(mq.size() > 0));
      chk("vrf_we", VW'(vrf_we), VW'(mq.size() > 0));
      chk("rf_we", VW'(rf_we), VW'(m_rf_we));
      chk("rf_waddr", VW'(rf_waddr), VW'(m_rf_waddr));
      chk("rf_wdata", VW'(rf_wdata), VW'(m_rf_wdata));
      if (mq.size() > 0) begin
         chk("vrf_waddr", VW'(vrf_waddr), VW'(mq[0].addr));
         chk("vrf_beat", VW'(vrf_beat), VW'(mq[0].beat));
         chk("vrf_wdata", VW'(vrf_wdata), VW'(mq[0].data));
      end else if (m_just_reset) begin
         chk("rst_vrf_waddr", VW'(vrf_waddr), '0);
         chk("rst_vrf_beat", VW'(vrf_beat), '0);
         chk("rst_vrf_wdata", VW'(vrf_wdata), '0);
      end
   endtask

   // Drive one cycle of inputs from the falling edge, then check after the next rising edge.
   task automatic cycle(input bit r, input bit v, input bit rw, input bit m2r, input bit vrw,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rd,
                        input logic [REG_AW-1:0] a, input logic [VW-1:0] vec);
      rst          = r;
      in_valid     = v;
      RegWrite_i   = rw;
      MemtoReg_i   = m2r;
      VRegWrite_i  = vrw;
      alu_result_i = alu;
      read_data_i  = rd;
      write_addr_i = a;
      vec_data_i   = vec;
`ifdef WB_FWD_EN
      #1;
      if (!r) begin
         chk("fwd_valid", VW'(fwd_valid), VW'(v && (mq.size() <= 1) && rw && (a != '0)));
      end
`endif
      model_step(r, v, rw, m2r, vrw, alu, rd, a, vec);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   function automatic logic [VW-1:0] lanes_seq(input int base);
      logic [VW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DATA_W +: DATA_W] = DATA_W'(base + k);
      return v;
   endfunction

   initial begin
      bit                hv, hrw, hm, hvr, pending, r;
      logic [DATA_W-1:0] ha, hr;
      logic [REG_AW-1:0] haddr;
      logic [VW-1:0]     hvec;

      n_checks = 0;
      n_errors = 0;
      m_rf_we = 1'b0; m_rf_waddr = '0; m_rf_wdata = '0; m_just_reset = 1'b0;
      rst = 1'b1; in_valid = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; VRegWrite_i = 1'b0;
      alu_result_i = '0; read_data_i = '0; write_addr_i = '0; vec_data_i = '0;
      @(negedge clk);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      chk("rst_ready_const", VW'(in_ready), VW'(1'b1));

      // Scalar writes, ALU and load sources, then the x0 guard
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, '0);
      chk("sc_we_const", VW'(rf_we), VW'(1'b1));
      chk("sc_addr_const", VW'(rf_waddr), VW'(5'd5));
      chk("sc_alu_const", VW'(rf_wdata), VW'(32'h1234));
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5555, 32'hBEEF, 5'd5, '0);
      chk("sc_load_const", VW'(rf_wdata), VW'(32'hBEEF));
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h9999, 32'h0, 5'd0, '0);
      chk("x0_we_const", VW'(rf_we), VW'(1'b0));
      chk("x0_hold_const", VW'(rf_wdata), VW'(32'hBEEF));

      // Vector drain of lanes 0x10..0x17 to v3
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 5'd3, lanes_seq(32'h10));
      chk("v_beat0_data", VW'(vrf_wdata), VW'(64'h00000011_00000010));
      chk("v_beat0_addr", VW'(vrf_waddr), VW'(5'd3));
      chk("v_beat0_ready", VW'(in_ready), VW'(1'b0));
      for (int b = 1; b < NBEATS; b++) begin
         idle();
         chk("v_beat_idx", VW'(vrf_beat), VW'(b));
         chk("v_beat_data", VW'(vrf_wdata), VW'({DATA_W'(32'h11 + 2*b), DATA_W'(32'h10 + 2*b)}));
         chk("v_beat_busy", VW'(busy), VW'(1'b1));
      end
      chk("v_last_ready", VW'(in_ready), VW'(1'b1));
      idle();
      chk("v_done_we", VW'(vrf_we), VW'(1'b0));

      // Back-to-back vector ops, with a scalar op queued behind the second
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 5'd4, lanes_seq(32'h20));
      for (int i = 0; i < NBEATS; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 5'd9, lanes_seq(32'h40));
      chk("b2b_addr", VW'(vrf_waddr), VW'(5'd9));
      chk("b2b_beat0", VW'(vrf_beat), VW'(0));
      chk("b2b_we", VW'(vrf_we), VW'(1'b1));
      for (int i = 0; i < NBEATS; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE, '0, 5'd12, '0);
      chk("queued_sc_we", VW'(rf_we), VW'(1'b1));
      chk("queued_sc_data", VW'(rf_wdata), VW'(32'hCAFE));
      idle();

      // Reset after beat 1 drops the rest of the drain
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 5'd6, lanes_seq(32'h60));
      idle();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      chk("mid_rst_we", VW'(vrf_we), VW'(1'b0));
      chk("mid_rst_busy", VW'(busy), VW'(1'b0));
      chk("mid_rst_ready", VW'(in_ready), VW'(1'b1));
      idle();
      chk("mid_rst_we2", VW'(vrf_we), VW'(1'b0));

      // Combined scalar + vector op to x7/v7
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77, '0, 5'd7, lanes_seq(32'h70));
      chk("comb_rf_we", VW'(rf_we), VW'(1'b1));
      chk("comb_vrf_we", VW'(vrf_we), VW'(1'b1));
      chk("comb_rf_addr", VW'(rf_waddr), VW'(5'd7));
      chk("comb_vrf_addr", VW'(vrf_waddr), VW'(5'd7));
      for (int i = 0; i < NBEATS; i++) idle();

      // Random traffic; a refused op is held until accepted, as upstream would
      pending = 1'b0;
      hv = 1'b0; hrw = 1'b0; hm = 1'b0; hvr = 1'b0; ha = '0; hr = '0; haddr = '0; hvec = '0;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 99) == 0);
         if (!pending) begin
            hv    = ($urandom_range(0, 9) < 7);
            hrw   = 1'($urandom_range(0, 1));
            hm    = 1'($urandom_range(0, 1));
            hvr   = ($urandom_range(0, 2) == 0);
            ha    = $urandom;
            hr    = $urandom;
            haddr = ($urandom_range(0, 7) == 0) ? 5'd0 : REG_AW'($urandom);
            for (int k = 0; k < LANES; k++) hvec[k*DATA_W +: DATA_W] = $urandom;
         end
         pending = hv && !r && (mq.size() > 1);
         cycle(r, hv, hrw, hm, hvr, ha, hr, haddr, hvec);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
